sequence_step_player: RTL and testbench
=======================================

Name: sequence_step_player

Overview:
- Buffered, parametrised sequence-step decoder.
- Accepts packed sequence words over a valid/ready stream into a small FIFO.
- On each step tick, pops one word and presents registered per-lane DAC/PDM values plus enable, ramp-down and reset flags to the signal-generation path.
- Tracks steps played and flags underflow when a tick finds the FIFO empty.

Parameters:
- LANES, 4, number of 16-bit lanes per step; each lane drives one DAC value and one PDM value.
- DAC_WIDTH, 14, DAC field width per lane (lane bits [DAC_WIDTH-1:0]); 2..16.
- PDM_WIDTH, 11, PDM field width per lane (lane bits [PDM_WIDTH-1:0]); 1..16.
- DEPTH, 4, FIFO depth in words; power of two, >= 2.
- CNT_WIDTH, 32, width of step counter.

Ports:
- clk  in  1  system clock.
- aresetn  in  1  asynchronous active-low reset.
- s_data  in  16*LANES  packed step data; lane i = s_data[16i+15:16i].
- s_flags  in  2*LANES+1  [LANES-1:0] enable per lane, [2*LANES-1:LANES] ramp_down per lane, [2*LANES] dac_reset.
- s_valid  in  1  word valid.
- s_ready  out  1  FIFO not full.
- step_tick  in  1  single-cycle advance strobe.
- clear  in  1  synchronous flush: empties FIFO, clears counter and underflow.
- dac_value  out  16*LANES  lane i DAC field, sign-extended from bit DAC_WIDTH-1 to 16 bits.
- pdm_value  out  PDM_WIDTH*LANES  lane i PDM field, zero-extended as-is.
- enable  out  LANES  registered enable flags.
- ramp_down  out  LANES  registered ramp-down flags.
- dac_reset  out  1  registered reset flag.
- step_valid  out  1  high once at least one step has been loaded since reset/clear.
- underflow  out  1  sticky: a tick occurred while the FIFO was empty.
- step_count  out  CNT_WIDTH  number of steps loaded since reset/clear; wraps.
- fill_level  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (aresetn low, asynchronous): all outputs 0. s_ready = 0 while in reset, 1 on the first cycle after release. FIFO empty; read and write pointers 0.
- Push: s_valid & s_ready on a rising edge writes the word and its flags. s_ready = (fill_level != DEPTH); it is registered and has no combinational dependence on step_tick.
- Pop: step_tick with fill_level > 0 reads the head word.
  - Decoded fields load into the output registers at the next edge (tick at cycle n, outputs valid at n+1).
  - step_count increments and step_valid is set.
- Decode is purely field extraction from the popped word.
  - DAC: lane bits [DAC_WIDTH-1:0], sign-extended from bit DAC_WIDTH-1.
  - PDM: lane bits [PDM_WIDTH-1:0].
  - Lane bits above each field are ignored.
- Simultaneous push and pop with the FIFO neither full nor empty: both happen; fill_level unchanged.
- Push to an empty FIFO in the same cycle as a tick: no bypass. The tick sees empty, underflow is set, and the pushed word is stored.
- Empty tick: underflow <= 1 (sticky). step_count is unchanged. Outputs behave per the optional feature.
- Full FIFO: s_ready = 0 and s_valid is ignored. A tick in that cycle pops, and s_ready rises the next cycle.
- Pointers wrap modulo DEPTH; step_count wraps at 2^CNT_WIDTH.
- clear (synchronous, takes priority over push/pop in the same cycle):
  - Empties the FIFO and zeroes step_count, underflow and step_valid.
  - Output value/flag registers keep their current contents.
- Mid-operation reset: everything returns to reset values immediately. No partial word survives.

Optional Feature:
- SEQ_UNDERFLOW_SAFE_EN.
  - Defined: an empty tick forces enable, ramp_down, dac_value and pdm_value to 0 and dac_reset to 1 on the next cycle, until the next successful pop.
  - Undefined: an empty tick leaves all outputs holding the last step; only underflow is set.

Test Plan:
- LANES=4, DAC_WIDTH=14: push lane0=0x2001, flags enable=0xF, then tick -> one cycle later dac_value lane0=0xE001, pdm_value lane0=0x001, enable=0xF, step_count=1, step_valid=1.
- DEPTH=4: push 4 words without ticks -> s_ready=0 and fill_level=4; 5th s_valid ignored; tick -> s_ready=1 next cycle; outputs = first word (FIFO order preserved over 4 ticks).
- Empty FIFO, tick -> underflow=1, step_count unchanged.
  - With SEQ_UNDERFLOW_SAFE_EN: enable=0 and dac_reset=1.
  - Without: outputs equal the previous step.
- Full FIFO except one slot (fill_level=3), push and tick in the same cycle -> fill_level stays 3 and the popped word appears next cycle; repeat for 8 cycles with no loss or duplication.
- clear asserted with s_valid and step_tick also high -> fill_level=0, step_count=0, underflow=0, step_valid=0; output registers unchanged; pushed word discarded.
- aresetn pulsed low mid-stream (fill_level=2) -> all outputs 0 immediately; after release, fill_level=0 and a subsequent push+tick plays the new word only.

Source files
------------

// File: rtl/sequence_step_player.sv
// Buffered sequence-step player: FIFO of packed step words, popped on step_tick into per-lane DAC/PDM registers.
// Optional SEQ_UNDERFLOW_SAFE_EN: an empty tick drives safe outputs (all zero, dac_reset high) until the next pop.
module sequence_step_player #(
  parameter int LANES     = 4,
  parameter int DAC_WIDTH = 14,
  parameter int PDM_WIDTH = 11,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           aresetn,
  input  logic [16*LANES-1:0]            s_data,
  input  logic [2*LANES:0]               s_flags,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic                           step_tick,
  input  logic                           clear,
  output logic [16*LANES-1:0]            dac_value,
  output logic [PDM_WIDTH*LANES-1:0]     pdm_value,
  output logic [LANES-1:0]               enable,
  output logic [LANES-1:0]               ramp_down,
  output logic                           dac_reset,
  output logic                           step_valid,
  output logic                           underflow,
  output logic [CNT_WIDTH-1:0]           step_count,
  output logic [$clog2(DEPTH):0]         fill_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] FULL_LEVEL = FILL_W'(DEPTH);

  logic [16*LANES-1:0]        mem_data_reg [DEPTH];
  logic [2*LANES:0]           mem_flags_reg [DEPTH];
  logic [PTR_W-1:0]           wr_ptr_reg, rd_ptr_reg;
  logic [FILL_W-1:0]          count_reg, count_next;
  logic                       s_ready_reg;
  logic [16*LANES-1:0]        dac_value_reg, dac_next;
  logic [PDM_WIDTH*LANES-1:0] pdm_value_reg, pdm_next;
  logic [LANES-1:0]           enable_reg, ramp_down_reg;
  logic                       dac_reset_reg, step_valid_reg, underflow_reg;
  logic [CNT_WIDTH-1:0]       step_count_reg;
  logic                       push, pop;
  logic [16*LANES-1:0]        head_data;
  logic [2*LANES:0]           head_flags;
  logic                       unused_head_bits;

  assign head_data  = mem_data_reg[rd_ptr_reg];
  assign head_flags = mem_flags_reg[rd_ptr_reg];
  // Lane bits above the DAC/PDM fields are deliberately discarded.
  assign unused_head_bits = ^head_data;

  // clear wins over both stream directions; a tick on an empty FIFO never bypasses a same-cycle push.
  always_comb begin
    push       = s_valid && s_ready_reg && !clear;
    pop        = step_tick && (count_reg != '0) && !clear;
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + FILL_W'(1);
        2'b01:   count_next = count_reg - FILL_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [15:0] lane_word;
      assign lane_word = head_data[16*gi +: 16];
      if (DAC_WIDTH == 16) begin : g_dac_full
        assign dac_next[16*gi +: 16] = lane_word;
      end else begin : g_dac_sext
        assign dac_next[16*gi +: 16] =
          {{(16-DAC_WIDTH){lane_word[DAC_WIDTH-1]}}, lane_word[DAC_WIDTH-1:0]};
      end
      assign pdm_next[PDM_WIDTH*gi +: PDM_WIDTH] = lane_word[PDM_WIDTH-1:0];
    end
  endgenerate

  // Storage array carries no reset so it maps onto RAM; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_reg[wr_ptr_reg]  <= s_data;
      mem_flags_reg[wr_ptr_reg] <= s_flags;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      s_ready_reg    <= 1'b0;
      dac_value_reg  <= '0;
      pdm_value_reg  <= '0;
      enable_reg     <= '0;
      ramp_down_reg  <= '0;
      dac_reset_reg  <= 1'b0;
      step_valid_reg <= 1'b0;
      underflow_reg  <= 1'b0;
      step_count_reg <= '0;
    end else begin
      count_reg   <= count_next;
      s_ready_reg <= (count_next != FULL_LEVEL);
      if (clear) begin
        wr_ptr_reg     <= '0;
        rd_ptr_reg     <= '0;
        step_count_reg <= '0;
        underflow_reg  <= 1'b0;
        step_valid_reg <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_reg     <= rd_ptr_reg + PTR_W'(1);
          step_count_reg <= step_count_reg + CNT_WIDTH'(1);
          step_valid_reg <= 1'b1;
          dac_value_reg  <= dac_next;
          pdm_value_reg  <= pdm_next;
          enable_reg     <= head_flags[LANES-1:0];
          ramp_down_reg  <= head_flags[2*LANES-1:LANES];
          dac_reset_reg  <= head_flags[2*LANES];
        end else if (step_tick) begin
          underflow_reg <= 1'b1;
`ifdef SEQ_UNDERFLOW_SAFE_EN
          dac_value_reg <= '0;
          pdm_value_reg <= '0;
          enable_reg    <= '0;
          ramp_down_reg <= '0;
          dac_reset_reg <= 1'b1;
`else
          // Outputs hold the last played step.
`endif
        end
      end
    end
  end

  assign s_ready    = s_ready_reg;
  assign dac_value  = dac_value_reg;
  assign pdm_value  = pdm_value_reg;
  assign enable     = enable_reg;
  assign ramp_down  = ramp_down_reg;
  assign dac_reset  = dac_reset_reg;
  assign step_valid = step_valid_reg;
  assign underflow  = underflow_reg;
  assign step_count = step_count_reg;
  assign fill_level = count_reg;

endmodule

// File: tb/tb_sequence_step_player.sv
// Directed testbench for sequence_step_player (default parameters: 4 lanes, DAC 14b, PDM 11b, depth 4).
// Expectations for empty ticks follow SEQ_UNDERFLOW_SAFE_EN when it is defined for the build.
module tb_sequence_step_player;

  logic        clk;
  logic        aresetn;
  logic [63:0] s_data;
  logic [8:0]  s_flags;
  logic        s_valid;
  logic        s_ready;
  logic        step_tick;
  logic        clear;
  logic [63:0] dac_value;
  logic [43:0] pdm_value;
  logic [3:0]  enable;
  logic [3:0]  ramp_down;
  logic        dac_reset;
  logic        step_valid;
  logic        underflow;
  logic [31:0] step_count;
  logic [2:0]  fill_level;

  int checks;
  int failures;

  sequence_step_player #(
    .LANES(4), .DAC_WIDTH(14), .PDM_WIDTH(11), .DEPTH(4), .CNT_WIDTH(32)
  ) dut (
    .clk(clk), .aresetn(aresetn), .s_data(s_data), .s_flags(s_flags),
    .s_valid(s_valid), .s_ready(s_ready), .step_tick(step_tick), .clear(clear),
    .dac_value(dac_value), .pdm_value(pdm_value), .enable(enable),
    .ramp_down(ramp_down), .dac_reset(dac_reset), .step_valid(step_valid),
    .underflow(underflow), .step_count(step_count), .fill_level(fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Directed FIFO-order words with hand-decoded DAC/PDM expectations.
  logic [63:0] w_data [4];
  logic [8:0]  w_flags [4];
  logic [63:0] w_dac [4];
  logic [43:0] w_pdm [4];

  initial begin
    w_data[0] = 64'h0000_0000_FFFF_0101; w_flags[0] = 9'h001;
    w_dac[0]  = 64'h0000_0000_FFFF_0101; w_pdm[0]  = {11'h000, 11'h000, 11'h7FF, 11'h101};
    w_data[1] = 64'h1FFF_0000_0000_0102; w_flags[1] = 9'h0F2;
    w_dac[1]  = 64'h1FFF_0000_0000_0102; w_pdm[1]  = {11'h7FF, 11'h000, 11'h000, 11'h102};
    w_data[2] = 64'h0000_3000_0000_0103; w_flags[2] = 9'h104;
    w_dac[2]  = 64'h0000_F000_0000_0103; w_pdm[2]  = {11'h000, 11'h000, 11'h000, 11'h103};
    w_data[3] = 64'hC7FF_0000_0000_0104; w_flags[3] = 9'h038;
    w_dac[3]  = 64'h07FF_0000_0000_0104; w_pdm[3]  = {11'h7FF, 11'h000, 11'h000, 11'h104};
  end

  initial begin
    checks = 0;
    failures = 0;
    aresetn = 1'b0;
    s_data = '0; s_flags = '0; s_valid = 1'b0; step_tick = 1'b0; clear = 1'b0;
    repeat (3) cycle();

    // Reset state
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_dac", dac_value, 64'd0);
    check("rst_count", 64'(step_count), 64'd0);
    check("rst_flags", 64'({step_valid, underflow, dac_reset, enable, ramp_down}), 64'd0);
    aresetn = 1'b1;
    cycle();
    check("rel_s_ready", 64'(s_ready), 64'd1);

    // Basic push then tick: lane0 0x2001 sign-extends from bit 13
    s_data = 64'h0000_0000_0000_2001; s_flags = 9'h00F; s_valid = 1'b1;
    cycle();
    s_valid = 1'b0;
    check("t1_fill", 64'(fill_level), 64'd1);
    step_tick = 1'b1;
    cycle();
    step_tick = 1'b0;
    check("t1_dac", dac_value, 64'h0000_0000_0000_E001);
    check("t1_pdm", 64'(pdm_value), 64'h1);
    check("t1_enable", 64'(enable), 64'hF);
    check("t1_count", 64'(step_count), 64'd1);
    check("t1_step_valid", 64'(step_valid), 64'd1);

    // Fill to DEPTH, fifth word ignored
    for (int i = 0; i < 4; i++) begin
      s_data = w_data[i]; s_flags = w_flags[i]; s_valid = 1'b1;
      cycle();
    end
    check("full_s_ready", 64'(s_ready), 64'd0);
    check("full_fill", 64'(fill_level), 64'd4);
    s_data = 64'hDEAD_BEEF_DEAD_BEEF; s_flags = 9'h1FF;
    cycle();
    s_valid = 1'b0;
    check("full_ignored_fill", 64'(fill_level), 64'd4);
    for (int i = 0; i < 4; i++) begin
      step_tick = 1'b1;
      cycle();
      check($sformatf("pop%0d_dac", i), dac_value, w_dac[i]);
      check($sformatf("pop%0d_pdm", i), 64'(pdm_value), 64'(w_pdm[i]));
      check($sformatf("pop%0d_flags", i), 64'({dac_reset, ramp_down, enable}), 64'(w_flags[i]));
      check($sformatf("pop%0d_count", i), 64'(step_count), 64'(i + 2));
      check($sformatf("pop%0d_fill", i), 64'(fill_level), 64'(3 - i));
      if (i == 0) check("pop0_s_ready", 64'(s_ready), 64'd1);
    end

    // Empty tick
    cycle();
    step_tick = 1'b0;
    check("uf_underflow", 64'(underflow), 64'd1);
    check("uf_count", 64'(step_count), 64'd5);
`ifdef SEQ_UNDERFLOW_SAFE_EN
    check("uf_enable", 64'(enable), 64'd0);
    check("uf_dac_reset", 64'(dac_reset), 64'd1);
    check("uf_dac", dac_value, 64'd0);
`else
    check("uf_enable", 64'(enable), 64'd8);
    check("uf_dac_reset", 64'(dac_reset), 64'd0);
    check("uf_dac", dac_value, w_dac[3]);
`endif

    // Push into empty FIFO with a same-cycle tick: stored, not bypassed
    s_data = 64'h0200; s_flags = 9'h000; s_valid = 1'b1; step_tick = 1'b1;
    cycle();
    step_tick = 1'b0;
    check("nobypass_fill", 64'(fill_level), 64'd1);
    check("nobypass_count", 64'(step_count), 64'd5);
    for (int k = 1; k < 3; k++) begin
      s_data = 64'(16'h0200 + k); s_flags = 9'(k);
      cycle();
    end
    check("steady_pre_fill", 64'(fill_level), 64'd3);

    // Steady state at fill 3: push and pop every cycle
    for (int k = 0; k < 8; k++) begin
      s_data = 64'(16'h0200 + k + 3); s_flags = 9'((k + 3) & 15);
      s_valid = 1'b1; step_tick = 1'b1;
      cycle();
      check($sformatf("steady%0d_dac", k), dac_value, 64'(16'h0200 + k));
      check($sformatf("steady%0d_enable", k), 64'(enable), 64'(k & 15));
      check($sformatf("steady%0d_fill", k), 64'(fill_level), 64'd3);
      check($sformatf("steady%0d_count", k), 64'(step_count), 64'(6 + k));
    end

    // clear with push and tick in the same cycle
    s_data = 64'hAAAA; s_flags = 9'h1FF; s_valid = 1'b1; step_tick = 1'b1; clear = 1'b1;
    cycle();
    s_valid = 1'b0; step_tick = 1'b0; clear = 1'b0;
    check("clr_fill", 64'(fill_level), 64'd0);
    check("clr_count", 64'(step_count), 64'd0);
    check("clr_underflow", 64'(underflow), 64'd0);
    check("clr_step_valid", 64'(step_valid), 64'd0);
    check("clr_dac_held", dac_value, 64'h0207);
    check("clr_enable_held", 64'(enable), 64'd7);
    cycle();
    check("clr_discard_fill", 64'(fill_level), 64'd0);

    // Mid-stream asynchronous reset at fill 2
    for (int k = 0; k < 3; k++) begin
      s_data = 64'(16'h0300 + k); s_flags = 9'h003; s_valid = 1'b1;
      cycle();
    end
    s_valid = 1'b0; step_tick = 1'b1;
    cycle();
    step_tick = 1'b0;
    check("mid_pre_dac", dac_value, 64'h0300);
    check("mid_pre_fill", 64'(fill_level), 64'd2);
    #2;
    aresetn = 1'b0;
    #1;
    check("mid_rst_dac", dac_value, 64'd0);
    check("mid_rst_fill", 64'(fill_level), 64'd0);
    check("mid_rst_count", 64'(step_count), 64'd0);
    check("mid_rst_flags", 64'({s_ready, step_valid, enable}), 64'd0);
    cycle();
    aresetn = 1'b1;
    cycle();
    check("mid_rel_fill", 64'(fill_level), 64'd0);
    check("mid_rel_s_ready", 64'(s_ready), 64'd1);
    s_data = 64'h0ABC; s_flags = 9'h005; s_valid = 1'b1;
    cycle();
    s_valid = 1'b0; step_tick = 1'b1;
    cycle();
    step_tick = 1'b0;
    check("mid_new_dac", dac_value, 64'h0ABC);
    check("mid_new_enable", 64'(enable), 64'd5);
    check("mid_new_count", 64'(step_count), 64'd1);
    check("mid_new_fill", 64'(fill_level), 64'd0);
    check("mid_new_underflow", 64'(underflow), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
